// File: rtl/proc_frame_sched_pkg.sv
// Shared types and helpers for the capture scheduler and its read-out side.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package proc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } t_sched_st;

  // Upper bound on channels; masks are zero-extended to this width.
  localparam int C_MAX_CHAN = 16;

  // Channel index width; a single channel still needs a one-bit index.
  function automatic int f_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next enabled channel strictly above cur, wrapping modulo n.
  // An empty mask returns cur unchanged.
  function automatic int f_next_chan(input logic [C_MAX_CHAN-1:0] mask,
                                     input int cur, input int n);
    int nxt;
    int idx;
    logic found;
    nxt   = cur;
    found = 1'b0;
    for (int i = 1; i <= C_MAX_CHAN; i++) begin
      idx = (cur + i) % n;
      if (!found && (i <= n) && mask[idx[3:0]]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/proc_frame_sched_if.sv
// Bundle of sample stream, run control, capture-memory write port and status.
// Latency: n/a (wires only).
// Backpressure: none; the stream source cannot be stalled.
// master = stream source / register bank / memory side, slave = scheduler.
interface proc_frame_sched_if #(
  parameter int G_BIT_WIDTH      = 16,
  parameter int G_CHAN_NUM       = 4,
  parameter int G_MEM_ADDR_WIDTH = 5,
  parameter int G_FRM_CNT_W      = 16
);
  localparam int CW = proc_sched_pkg::f_cw(G_CHAN_NUM);

  logic [G_BIT_WIDTH-1:0]      s_tdata;
  logic                        s_tvalid;
  logic                        s_tlast;
  logic                        i_start;
  logic                        i_abort;
  logic [G_CHAN_NUM-1:0]       i_chan_mask;
  logic [G_FRM_CNT_W-1:0]      i_frames;
  logic                        o_mem_we;
  logic [CW-1:0]               o_mem_chan;
  logic [G_MEM_ADDR_WIDTH-1:0] o_mem_addr;
  logic [G_BIT_WIDTH-1:0]      o_mem_data;
  logic                        o_busy;
  logic                        o_done;
  logic [G_FRM_CNT_W-1:0]      o_frame_cnt;
  logic                        o_trunc;
  logic [G_MEM_ADDR_WIDTH:0]   o_last_len;

  modport master (
    output s_tdata, s_tvalid, s_tlast, i_start, i_abort, i_chan_mask, i_frames,
    input  o_mem_we, o_mem_chan, o_mem_addr, o_mem_data,
           o_busy, o_done, o_frame_cnt, o_trunc, o_last_len
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, i_start, i_abort, i_chan_mask, i_frames,
    output o_mem_we, o_mem_chan, o_mem_addr, o_mem_data,
           o_busy, o_done, o_frame_cnt, o_trunc, o_last_len
  );
endinterface

// File: rtl/proc_rr_pick.sv
// Combinational round-robin selector: next enabled channel above i_cur, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_mask enabled channels, i_cur current index, o_next selected index.
module proc_rr_pick
  import proc_sched_pkg::*;
#(
  parameter int G_CHAN_NUM = 4,
  localparam int CW        = f_cw(G_CHAN_NUM)
) (
  input  logic [G_CHAN_NUM-1:0] i_mask,
  input  logic [CW-1:0]         i_cur,
  output logic [CW-1:0]         o_next
);

  logic [C_MAX_CHAN-1:0] mask_ext;

  always_comb begin
    mask_ext                 = '0;
    mask_ext[G_CHAN_NUM-1:0] = i_mask;
    o_next = CW'(f_next_chan(mask_ext, int'(i_cur), G_CHAN_NUM));
  end

endmodule

// File: rtl/proc_frame_sched.sv
// Capture scheduler: N frames from the sample stream, round-robin over enabled channels.
// Latency: 1 cycle sample-to-write; all outputs registered.
// Backpressure: none; samples beyond frame capacity are dropped and flagged.
// Ports: i_clk/i_rst (sync, active high); bus.slave carries stream, run control,
// memory write port (we/chan/addr/data) and status (busy/done/frame_cnt/trunc/last_len).
module proc_frame_sched
  import proc_sched_pkg::*;
#(
  parameter int G_BYT            = 2,
  parameter int G_BIT_WIDTH      = 8 * G_BYT,
  parameter int G_CHAN_NUM       = 4,
  parameter int G_MEM_ADDR_WIDTH = 5,
  parameter int G_FRM_CNT_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  proc_frame_sched_if.slave  bus
);

  localparam int AW = G_MEM_ADDR_WIDTH;
  localparam int CW = f_cw(G_CHAN_NUM);
  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

  t_sched_st               state_q, state_d;
  logic [G_CHAN_NUM-1:0]   mask_q, mask_d;
  logic [G_FRM_CNT_W-1:0]  frames_q, frames_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic [AW:0]             len_q, len_d;         // samples written in current frame
  logic                    in_frm_q, in_frm_d;   // stream is between first sample and tlast
  logic [G_FRM_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                    trunc_q, trunc_d;
  logic [AW:0]             last_len_q, last_len_d;
  logic                    we_q, we_d;
  logic [CW-1:0]           mem_chan_q, mem_chan_d;
  logic [AW-1:0]           mem_addr_q, mem_addr_d;
  logic [G_BIT_WIDTH-1:0]  mem_data_q, mem_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    start_ok;
  logic                    frm_full;
  logic                    frm_end;
  logic                    last_frame;
  logic [G_CHAN_NUM-1:0]   pick_mask;
  logic [CW-1:0]           pick_cur;
  logic [CW-1:0]           rr_next;

  // The done cycle counts as busy even though the FSM is already back in IDLE.
  assign start_ok   = (state_q == ST_IDLE) && !done_q && bus.i_start &&
                      (bus.i_chan_mask != '0) && (bus.i_frames != '0);
  assign in_frm_d   = bus.s_tvalid ? !bus.s_tlast : in_frm_q;
  assign frm_full   = (len_q == CAP);
  assign frm_end    = (state_q == ST_CAPT) && bus.s_tvalid && bus.s_tlast && !bus.i_abort;
  assign last_frame = frm_end && ((frame_cnt_q + 1'b1) == frames_q);
  assign done_d     = (state_q == ST_DONE) && !bus.i_abort;
  assign busy_d     = (state_d != ST_IDLE) || done_d;

  // At start the lowest enabled bit is the "next" one above the top index.
  assign pick_mask = (state_q == ST_IDLE) ? bus.i_chan_mask : mask_q;
  assign pick_cur  = (state_q == ST_IDLE) ? CW'(G_CHAN_NUM - 1) : chan_q;

  proc_rr_pick #(.G_CHAN_NUM(G_CHAN_NUM)) u_rr_pick (
    .i_mask (pick_mask),
    .i_cur  (pick_cur),
    .o_next (rr_next)
  );

  always_ff @(posedge i_clk) begin : p_state_reg
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : p_next_state
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = in_frm_d ? ST_SYNC : ST_CAPT;
      ST_SYNC: begin
        if (bus.i_abort)                         state_d = ST_IDLE;
        else if (bus.s_tvalid && bus.s_tlast)    state_d = ST_CAPT;
      end
      ST_CAPT: begin
        if (bus.i_abort)      state_d = ST_IDLE;
        else if (last_frame)  state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : p_outputs
    mask_d      = mask_q;
    frames_d    = frames_q;
    chan_d      = chan_q;
    len_d       = len_q;
    frame_cnt_d = frame_cnt_q;
    trunc_d     = trunc_q;
    last_len_d  = last_len_q;
    we_d        = 1'b0;
    mem_chan_d  = mem_chan_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;

    if (start_ok) begin
      mask_d      = bus.i_chan_mask;
      frames_d    = bus.i_frames;
      frame_cnt_d = '0;
      trunc_d     = 1'b0;
      len_d       = '0;
      chan_d      = rr_next;
    end

    if ((state_q == ST_CAPT) && bus.s_tvalid) begin
      // The write itself is not cancelled by abort; only frame bookkeeping is.
      if (!frm_full) begin
        we_d       = 1'b1;
        mem_chan_d = chan_q;
        mem_addr_d = len_q[AW-1:0];
        mem_data_d = bus.s_tdata;
      end
      if (!bus.i_abort) begin
        if (frm_full) trunc_d = 1'b1;
        else          len_d   = len_q + 1'b1;
        if (frm_end) begin
          last_len_d  = frm_full ? len_q : len_q + 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
          len_d       = '0;
          chan_d      = rr_next;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin : p_dp_reg
    if (i_rst) begin
      mask_q      <= '0;
      frames_q    <= '0;
      chan_q      <= '0;
      len_q       <= '0;
      in_frm_q    <= 1'b0;
      frame_cnt_q <= '0;
      trunc_q     <= 1'b0;
      last_len_q  <= '0;
      we_q        <= 1'b0;
      mem_chan_q  <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      frames_q    <= frames_d;
      chan_q      <= chan_d;
      len_q       <= len_d;
      in_frm_q    <= in_frm_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_q     <= trunc_d;
      last_len_q  <= last_len_d;
      we_q        <= we_d;
      mem_chan_q  <= mem_chan_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_chan  = mem_chan_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_data  = mem_data_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_frame_cnt = frame_cnt_q;
  assign bus.o_trunc     = trunc_q;
  assign bus.o_last_len  = last_len_q;

endmodule

// File: tb/tb_proc_frame_sched.sv
// Self-checking bench for proc_frame_sched: random sample data and frame shapes
// against a frame-level model (enabled-channel list, per-frame expected writes).
module tb_proc_frame_sched;

  localparam int AW  = 5;
  localparam int CH  = 4;
  localparam int DW  = 16;
  localparam int FW  = 16;
  localparam int CAP = 32;

  typedef struct packed {
    logic [1:0]  chan;
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proc_frame_sched_if #(.G_BIT_WIDTH(DW), .G_CHAN_NUM(CH),
                        .G_MEM_ADDR_WIDTH(AW), .G_FRM_CNT_W(FW)) bus ();

  proc_frame_sched #(.G_BYT(2), .G_BIT_WIDTH(DW), .G_CHAN_NUM(CH),
                     .G_MEM_ADDR_WIDTH(AW), .G_FRM_CNT_W(FW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int  vectors = 0;
  int  errors  = 0;
  int  done_seen = 0;
  wr_t exp_q[$];
  wr_t got_q[$];
  int  en_list[$];
  int  rr_idx;

  always @(negedge clk) begin
    if (bus.o_mem_we === 1'b1)
      got_q.push_back(wr_t'{chan: bus.o_mem_chan, addr: bus.o_mem_addr, data: bus.o_mem_data});
    if (bus.o_done === 1'b1) done_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_mask(input logic [3:0] m);
    en_list.delete();
    for (int i = 0; i < CH; i++) if (m[i]) en_list.push_back(i);
    rr_idx = 0;
  endtask

  task automatic idle(input int n);
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.i_start = 1'b0; bus.i_abort = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [3:0] m, input logic [15:0] f);
    bus.i_chan_mask = m; bus.i_frames = f; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Drives one frame; when capt is set, the model records the writes it implies.
  task automatic send_frame(input int len, input bit capt, input int max_gap, input bit abort_last);
    logic [15:0] d;
    for (int i = 0; i < len; i++) begin
      if (max_gap > 0) begin
        bus.s_tvalid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) tick();
      end
      d = 16'($urandom);
      bus.s_tdata  = d;
      bus.s_tvalid = 1'b1;
      bus.s_tlast  = (i == len - 1);
      bus.i_abort  = abort_last && (i == len - 1);
      if (capt && i < CAP)
        exp_q.push_back(wr_t'{chan: 2'(en_list[rr_idx]), addr: 5'(i), data: d});
      tick();
    end
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.i_abort = 1'b0;
    if (capt) rr_idx = (rr_idx + 1) % en_list.size();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.o_busy === 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      vectors++; errors++;
      $display("FAIL wait_idle busy still %b after 200 cycles, want 0", bus.o_busy);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    vectors++; if (bus.o_mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", bus.o_mem_we); end
    vectors++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
    vectors++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.o_done); end
    vectors++; if (bus.o_frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt got=%0d exp=0", bus.o_frame_cnt); end
    vectors++; if (bus.o_trunc !== 1'b0) begin errors++; $display("FAIL rst_trunc got=%b exp=0", bus.o_trunc); end
    vectors++; if (bus.o_last_len !== 6'd0) begin errors++; $display("FAIL rst_last_len got=%0d exp=0", bus.o_last_len); end
    vectors++; if ({bus.o_mem_chan, bus.o_mem_addr, bus.o_mem_data} !== 23'd0) begin
      errors++; $display("FAIL rst_mem_port got=%h exp=0", {bus.o_mem_chan, bus.o_mem_addr, bus.o_mem_data}); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_rr_capture();
    int d0;
    got_q.delete(); exp_q.delete();
    model_mask(4'b1011);
    d0 = done_seen;
    do_start(4'b1011, 16'd3);
    vectors++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rr_busy_rise got=%b exp=1", bus.o_busy); end
    send_frame(8, 1, 2, 0);
    send_frame(8, 1, 2, 0);
    send_frame(8, 1, 0, 0);
    vectors++; if (bus.o_mem_we !== 1'b1 || bus.o_mem_chan !== 2'd3 || bus.o_mem_addr !== 5'd7) begin
      errors++; $display("FAIL rr_last_write got we=%b chan=%0d addr=%0d exp we=1 chan=3 addr=7",
                         bus.o_mem_we, bus.o_mem_chan, bus.o_mem_addr); end
    vectors++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL rr_done_early got=%b exp=0", bus.o_done); end
    vectors++; if (bus.o_frame_cnt !== 16'd3) begin errors++; $display("FAIL rr_frame_cnt got=%0d exp=3", bus.o_frame_cnt); end
    vectors++; if (bus.o_last_len !== 6'd8) begin errors++; $display("FAIL rr_last_len got=%0d exp=8", bus.o_last_len); end
    tick();
    vectors++; if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL rr_done_pulse got done=%b busy=%b exp done=1 busy=1", bus.o_done, bus.o_busy); end
    // A start during the done cycle must be ignored.
    bus.i_chan_mask = 4'b1111; bus.i_frames = 16'd1; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    vectors++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL rr_done_fall got done=%b busy=%b exp done=0 busy=0", bus.o_done, bus.o_busy); end
    tick();
    vectors++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rr_start_in_done got busy=%b exp=0", bus.o_busy); end
    vectors++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL rr_done_count got=%0d exp=1", done_seen - d0); end
    vectors++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rr_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL rr_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 6; r++) begin
      logic [3:0] m;
      int nf, len, exp_last, d0;
      bit exp_trunc;
      m  = 4'($urandom_range(15, 1));
      nf = $urandom_range(4, 1);
      got_q.delete(); exp_q.delete();
      model_mask(m);
      d0 = done_seen;
      exp_trunc = 1'b0;
      exp_last  = 0;
      do_start(m, 16'(nf));
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(40, 1);
        if (len > CAP) exp_trunc = 1'b1;
        exp_last = (len > CAP) ? CAP : len;
        send_frame(len, 1, 1, 0);
      end
      vectors++; if (bus.o_frame_cnt !== 16'(nf)) begin errors++; $display("FAIL rnd%0d_frame_cnt got=%0d exp=%0d", r, bus.o_frame_cnt, nf); end
      vectors++; if (bus.o_last_len !== 6'(exp_last)) begin errors++; $display("FAIL rnd%0d_last_len got=%0d exp=%0d", r, bus.o_last_len, exp_last); end
      vectors++; if (bus.o_trunc !== exp_trunc) begin errors++; $display("FAIL rnd%0d_trunc got=%b exp=%b", r, bus.o_trunc, exp_trunc); end
      wait_idle();
      vectors++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL rnd%0d_done_count got=%0d exp=1", r, done_seen - d0); end
      vectors++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_wr_count got=%0d exp=%0d", r, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin errors++;
          $display("FAIL rnd%0d_wr[%0d] got=%h exp=%h", r, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_sync_start();
    got_q.delete(); exp_q.delete();
    model_mask(4'b0100);
    for (int i = 0; i < 5; i++) begin
      bus.s_tdata = 16'($urandom); bus.s_tvalid = 1'b1; bus.s_tlast = 1'b0;
      tick();
    end
    bus.s_tvalid = 1'b0;
    do_start(4'b0100, 16'd1);
    vectors++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL sync_busy got=%b exp=1", bus.o_busy); end
    send_frame(3, 0, 1, 0);
    send_frame(8, 1, 1, 0);
    vectors++; if (bus.o_frame_cnt !== 16'd1) begin errors++; $display("FAIL sync_frame_cnt got=%0d exp=1", bus.o_frame_cnt); end
    vectors++; if (bus.o_last_len !== 6'd8) begin errors++; $display("FAIL sync_last_len got=%0d exp=8", bus.o_last_len); end
    wait_idle();
    vectors++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sync_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL sync_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_trunc();
    got_q.delete(); exp_q.delete();
    model_mask(4'b0110);
    do_start(4'b0110, 16'd2);
    send_frame(40, 1, 0, 0);
    vectors++; if (bus.o_last_len !== 6'd32) begin errors++; $display("FAIL trunc_last_len got=%0d exp=32", bus.o_last_len); end
    vectors++; if (bus.o_trunc !== 1'b1) begin errors++; $display("FAIL trunc_flag got=%b exp=1", bus.o_trunc); end
    vectors++; if (bus.o_mem_we !== 1'b0) begin errors++; $display("FAIL trunc_dropped_we got=%b exp=0", bus.o_mem_we); end
    send_frame(6, 1, 1, 0);
    vectors++; if (bus.o_last_len !== 6'd6) begin errors++; $display("FAIL trunc_next_len got=%0d exp=6", bus.o_last_len); end
    vectors++; if (bus.o_trunc !== 1'b1) begin errors++; $display("FAIL trunc_sticky got=%b exp=1", bus.o_trunc); end
    wait_idle();
    vectors++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL trunc_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL trunc_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    int d0;
    got_q.delete(); exp_q.delete();
    model_mask(4'b1111);
    d0 = done_seen;
    do_start(4'b1111, 16'd4);
    send_frame(8, 1, 1, 0);
    send_frame(36, 1, 0, 1);
    vectors++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.o_busy); end
    vectors++; if (bus.o_frame_cnt !== 16'd1) begin errors++; $display("FAIL abort_frame_cnt got=%0d exp=1", bus.o_frame_cnt); end
    vectors++; if (bus.o_trunc !== 1'b1) begin errors++; $display("FAIL abort_trunc got=%b exp=1", bus.o_trunc); end
    vectors++; if (bus.o_last_len !== 6'd8) begin errors++; $display("FAIL abort_last_len got=%0d exp=8", bus.o_last_len); end
    idle(3);
    vectors++; if (done_seen !== d0) begin errors++; $display("FAIL abort_no_done got=%0d exp=%0d", done_seen, d0); end
    vectors++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL abort_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    model_mask(4'b0001);
    do_start(4'b0001, 16'd1);
    vectors++; if (bus.o_frame_cnt !== 16'd0 || bus.o_trunc !== 1'b0) begin
      errors++; $display("FAIL abort_restart_clear got cnt=%0d trunc=%b exp cnt=0 trunc=0", bus.o_frame_cnt, bus.o_trunc); end
    send_frame(3, 1, 1, 0);
    wait_idle();
    vectors++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL abort_restart_done got=%0d exp=1", done_seen - d0); end
    vectors++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_restart_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL abort_restart_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ignored_start();
    idle(2);
    do_start(4'b0000, 16'd3);
    vectors++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL ign_mask0_busy got=%b exp=0", bus.o_busy); end
    do_start(4'b0011, 16'd0);
    vectors++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL ign_frames0_busy got=%b exp=0", bus.o_busy); end
    vectors++; if (bus.o_frame_cnt !== 16'd1) begin errors++; $display("FAIL ign_frame_cnt_kept got=%0d exp=1", bus.o_frame_cnt); end
    got_q.delete(); exp_q.delete();
    model_mask(4'b0100);
    do_start(4'b0100, 16'd2);
    do_start(4'b0001, 16'd1);
    vectors++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL ign_busy_start got=%b exp=1", bus.o_busy); end
    send_frame(5, 1, 1, 0);
    send_frame(5, 1, 1, 0);
    vectors++; if (bus.o_frame_cnt !== 16'd2) begin errors++; $display("FAIL ign_frame_cnt got=%0d exp=2", bus.o_frame_cnt); end
    wait_idle();
    vectors++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ign_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL ign_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    model_mask(4'b1010);
    do_start(4'b1010, 16'd2);
    for (int i = 0; i < 4; i++) begin
      bus.s_tdata = 16'($urandom); bus.s_tvalid = 1'b1; bus.s_tlast = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    vectors++; if ({bus.o_mem_we, bus.o_busy, bus.o_done, bus.o_trunc} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags got we/busy/done/trunc=%b exp=0000",
                         {bus.o_mem_we, bus.o_busy, bus.o_done, bus.o_trunc}); end
    vectors++; if ({bus.o_frame_cnt, bus.o_last_len, bus.o_mem_chan, bus.o_mem_addr, bus.o_mem_data} !== 45'd0) begin
      errors++; $display("FAIL rstmid_values got=%h exp=0",
                         {bus.o_frame_cnt, bus.o_last_len, bus.o_mem_chan, bus.o_mem_addr, bus.o_mem_data}); end
    rst = 1'b0;
    idle(1);
    got_q.delete(); exp_q.delete();
    d0 = done_seen;
    do_start(4'b1010, 16'd1);
    send_frame(6, 1, 1, 0);
    vectors++; if (bus.o_frame_cnt !== 16'd1 || bus.o_last_len !== 6'd6) begin
      errors++; $display("FAIL rstmid_status got cnt=%0d len=%0d exp cnt=1 len=6", bus.o_frame_cnt, bus.o_last_len); end
    wait_idle();
    vectors++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL rstmid_done got=%0d exp=1", done_seen - d0); end
    vectors++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL rstmid_wr[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_chan_mask = '0; bus.i_frames = '0;
    rst = 1'b1;
    test_reset();
    test_rr_capture();
    test_random_runs();
    test_sync_start();
    test_trunc();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
